// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, memory map and FSM states for the division mini-CPU
// Optional build macro: DIV_ZERO_FLAG_EN adds the WR_FLG state.
package cpu_pkg;

    localparam int DW_DEF   = 8;
    localparam int AW_DEF   = 8;
    localparam int ADDR_DVD = 0;
    localparam int ADDR_DVS = 2;
    localparam int ADDR_QUO = 4;
    localparam int ADDR_REM = 5;
    localparam int ADDR_FLG = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_DVD = 3'd1,
        LD_DVS = 3'd2,
        DIV    = 3'd3,
        WR_QUO = 3'd4,
        WR_REM = 3'd5,
`ifdef DIV_ZERO_FLAG_EN
        WR_FLG = 3'd6,
`endif
        DONE   = 3'd7
    } state_e;

endpackage

// File: rtl/cpu_if.sv
// rtl/cpu_if.sv - start/ack run handshake between the mini-CPU and its host
interface cpu_if;

    logic start;
    logic ack;

    modport master (output start, input ack);
    modport slave  (input start, output ack);

endinterface

// File: rtl/cpu_data_mem.sv
// rtl/cpu_data_mem.sv - data memory: combinational read, synchronous write, no reset
module data_mem #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    reg [DW-1:0] core [0:2**AW-1];

    always_ff @(posedge clk) begin
        if (we) begin
            core[waddr] <= wdata;
        end
    end

    assign rdata = core[raddr];

endmodule

// File: rtl/cpu.sv
// rtl/cpu.sv - fixed-program mini-CPU: restoring 8-bit division on operands held in DM1
// Optional build macro: DIV_ZERO_FLAG_EN writes a divide-by-zero flag word after the remainder.
module cpu
    import cpu_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int A_DVD = ADDR_DVD,
    parameter int A_DVS = ADDR_DVS,
    parameter int A_QUO = ADDR_QUO,
    parameter int A_REM = ADDR_REM
) (
    input  logic  clk,
    input  logic  reset,
    cpu_if.slave  bus
);

    localparam int CW = $clog2(DW) + 1;

    state_e        state_q, state_d;
    logic          ack_q, ack_d;
    logic          start_q;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] q_q, q_d;
    logic [DW-1:0] r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;

    // Partial remainder is one bit wider than the divisor so the compare cannot overflow.
    logic [DW:0]   t;
    logic          t_ge_b;
    logic [DW-1:0] t_minus_b;

    data_mem #(.DW(DW), .AW(AW)) DM1 (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign t         = {r_q, q_q[DW-1]};
    assign t_ge_b    = (t >= {1'b0, b_q});
    assign t_minus_b = t[DW-1:0] - b_q;
    assign mem_raddr = (state_q == LD_DVD) ? AW'(A_DVD) : AW'(A_DVS);

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        a_d       = a_q;
        b_d       = b_q;
        q_d       = q_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (!bus.start && !start_q) begin
                    state_d = LD_DVD;
                end
            end
            LD_DVD: begin
                a_d     = mem_rdata;
                state_d = LD_DVS;
            end
            LD_DVS: begin
                b_d   = mem_rdata;
                cnt_d = '0;
                if (mem_rdata == '0) begin
                    q_d     = '1;
                    r_d     = a_q;
                    state_d = WR_QUO;
                end else begin
                    q_d     = a_q;
                    r_d     = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                q_d   = {q_q[DW-2:0], t_ge_b};
                r_d   = t_ge_b ? t_minus_b : t[DW-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = WR_QUO;
                end
            end
            WR_QUO: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(A_QUO);
                mem_wdata = q_q;
                state_d   = WR_REM;
            end
            WR_REM: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(A_REM);
                mem_wdata = r_q;
`ifdef DIV_ZERO_FLAG_EN
                state_d   = WR_FLG;
`else
                state_d   = DONE;
`endif
            end
`ifdef DIV_ZERO_FLAG_EN
            WR_FLG: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(ADDR_FLG);
                mem_wdata = (b_q == '0) ? DW'(1) : '0;
                state_d   = DONE;
            end
`endif
            DONE: begin
                if (bus.start) begin
                    state_d = IDLE;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // start_q resets high so a launch always needs start seen low on two edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            start_q <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            start_q <= bus.start;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ack = ack_q;

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - directed self-checking bench for the division mini-CPU
module tb_cpu;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] prev_q;
    logic [7:0] prev_r;

`ifdef DIV_ZERO_FLAG_EN
    localparam int FLG_LAT = 1;
`else
    localparam int FLG_LAT = 0;
`endif

    cpu_if bus();

    cpu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with start_q high; returns at a negedge after the start pulse.
    task automatic run(input string tag, input logic [7:0] dvd, input logic [7:0] dvs,
                       input logic [7:0] exp_q, input logic [7:0] exp_r, input int exp_lat);
        int k;
        bit seen;
        dut.DM1.core[0] = dvd;
        dut.DM1.core[2] = dvs;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " ack_low_after_launch"}, 32'(bus.ack), 32'd0);
        k = 0;
        seen = 1'b0;
        while (k < 40 && !seen) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (bus.ack === 1'b1) seen = 1'b1;
        end
        chk({tag, " latency"}, 32'(k), 32'(exp_lat + FLG_LAT));
        chk({tag, " quotient"}, 32'(dut.DM1.core[4]), 32'(exp_q));
        chk({tag, " remainder"}, 32'(dut.DM1.core[5]), 32'(exp_r));
`ifdef DIV_ZERO_FLAG_EN
        chk({tag, " zero_flag"}, 32'(dut.DM1.core[6]), (dvs == 8'd0) ? 32'd1 : 32'd0);
`else
        chk({tag, " core6_untouched"}, 32'(dut.DM1.core[6]), 32'hA5);
`endif
        @(posedge clk);
        @(negedge clk);
        chk({tag, " ack_held"}, 32'(bus.ack), 32'd1);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " ack_drop"}, 32'(bus.ack), 32'd0);
        prev_q = exp_q;
        prev_r = exp_r;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b1;
        for (int i = 0; i < 256; i++) dut.DM1.core[i] = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        chk("reset ack", 32'(bus.ack), 32'd0);
        reset = 1'b0;

        run("4/2",     8'd4,   8'd2,   8'd2,   8'd0,   13);
        run("200/7",   8'd200, 8'd7,   8'd28,  8'd4,   13);
        run("3/255",   8'd3,   8'd255, 8'd0,   8'd3,   13);
        run("255/1",   8'd255, 8'd1,   8'd255, 8'd0,   13);
        run("250/129", 8'd250, 8'd129, 8'd1,   8'd121, 13);
        run("9/0",     8'd9,   8'd0,   8'd255, 8'd9,   5);

        // Abort a 50/3 run in the middle of DIV.
        dut.DM1.core[0] = 8'd50;
        dut.DM1.core[2] = 8'd3;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort ack", 32'(bus.ack), 32'd0);
        chk("abort quotient kept", 32'(dut.DM1.core[4]), 32'(prev_q));
        chk("abort remainder kept", 32'(dut.DM1.core[5]), 32'(prev_r));

        run("100/10",  8'd100, 8'd10,  8'd10,  8'd0,   13);
        run("130/200", 8'd130, 8'd200, 8'd0,   8'd130, 13);

        chk("core1 untouched", 32'(dut.DM1.core[1]), 32'hA5);
        chk("core3 untouched", 32'(dut.DM1.core[3]), 32'hA5);
        chk("core7 untouched", 32'(dut.DM1.core[7]), 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
